if_fetch_stage: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and produces its D payload.

---
 rtl/if_fetch_stage.sv | 97 +++++++++
 tb/tb_if_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to instruction
// memory, and holds one fetched instruction for the IF/ID register.
//
// state  | meaning
// -------+----------------------------------------------------
// S_IDLE | no request outstanding; may issue from pc
// S_WAIT | request outstanding at req_addr, waiting for ready
module if_fetch_stage #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4,
   output logic [DATA_W-1:0] if_instr
);

   localparam logic [0:0]        S_IDLE = 1'b0;
   localparam logic [0:0]        S_WAIT = 1'b1;
   localparam logic [ADDR_W-1:0] FOUR   = ADDR_W'(4);

   logic [0:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_addr;
   logic              kill;
   logic              issue;
   logic              accept;

   // A new request is only issued when the slot will be free by the time data lands.
   assign issue     = (state == S_IDLE) & ~redirect_valid & (~if_valid | ~stall);
   assign imem_req  = issue | (state == S_WAIT);
   assign imem_addr = (state == S_WAIT) ? req_addr : pc;
   assign accept    = imem_req & imem_ready & ~kill & ~redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         req_addr <= '0;
         kill     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue & ~imem_ready) begin
                  state    <= S_WAIT;
                  req_addr <= pc;
               end
            end
            default: begin
               // The request is never withdrawn; a redirect only marks its data as stale.
               if (imem_ready) begin
                  state <= S_IDLE;
                  kill  <= 1'b0;
               end else if (redirect_valid) begin
                  kill  <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc;
      end else if (accept) begin
         pc <= imem_addr + FOUR;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_valid    <= 1'b0;
         if_pc       <= '0;
         if_pc_plus4 <= '0;
         if_instr    <= '0;
      end else if (accept) begin
         if_valid    <= 1'b1;
         if_pc       <= imem_addr;
         if_pc_plus4 <= imem_addr + FOUR;
         if_instr    <= imem_rdata;
      end else if (redirect_valid | ~stall) begin
         if_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, a mid-request reset, then
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_rdata = memf(imem_addr);

   if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        s;
      logic        r;
      logic [31:0] rp;
      logic        rd;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] epc;
   } vec_t;

   vec_t tv[24];

   // reference model state: fetch pointer, outstanding request, output slot
   logic [31:0] m_pc;
   logic        m_busy;
   logic [31:0] m_busy_addr;
   logic        m_doomed;
   logic        m_v;
   logic [31:0] m_spc;
   logic [31:0] m_instr;

   initial begin
      logic        s, r, rd, ereq, done;
      logic [31:0] rp, eaddr, rnd;

      tv[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
      tv[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0};
      tv[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 32'h4};
      tv[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        1'b1, 32'h8};
      tv[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        1'b1, 32'h8};
      tv[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        1'b1, 32'h8};
      tv[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 32'h8};
      tv[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b1, 32'hC};
      tv[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b0, 32'hC};
      tv[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b0, 32'hC};
      tv[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b0, 32'hC};
      tv[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       1'b1, 32'h10};
      tv[12] = '{1'b0, 1'b1, 32'h100,      1'b0, 1'b1, 32'h14,       1'b0, 32'h10};
      tv[13] = '{1'b0, 1'b1, 32'h180,      1'b0, 1'b1, 32'h14,       1'b0, 32'h10};
      tv[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       1'b0, 32'h10};
      tv[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h180,      1'b0, 32'h10};
      tv[16] = '{1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 32'h184,      1'b1, 32'h180};
      tv[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0, 32'h180};
      tv[18] = '{1'b0, 1'b1, 32'h300,      1'b1, 1'b1, 32'h200,      1'b0, 32'h180};
      tv[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      1'b0, 32'h180};
      tv[20] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h304,      1'b1, 32'h300};
      tv[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h300};
      tv[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 32'hFFFFFFFC};
      tv[23] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 32'h0};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_pc",    if_pc,         32'h0);
      chk("rst_pc4",   if_pc_plus4,   32'h0);
      chk("rst_instr", if_instr,      32'h0);
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         stall          = tv[i].s;
         redirect_valid = tv[i].r;
         redirect_pc    = tv[i].rp;
         imem_ready     = tv[i].rd;
         #1;
         chk($sformatf("t%0d_req", i),   32'(imem_req), 32'(tv[i].ereq));
         chk($sformatf("t%0d_addr", i),  imem_addr,     tv[i].eaddr);
         chk($sformatf("t%0d_valid", i), 32'(if_valid), 32'(tv[i].ev));
         chk($sformatf("t%0d_pc", i),    if_pc,         tv[i].epc);
         if (tv[i].ev) begin
            chk($sformatf("t%0d_pc4", i),   if_pc_plus4, tv[i].epc + 32'd4);
            chk($sformatf("t%0d_instr", i), if_instr,    memf(tv[i].epc));
         end
         @(negedge clk);
      end

      // request to 0x4 is now outstanding; reset in the middle of it
      stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0;
      #1;
      chk("wait_req",  32'(imem_req), 32'h1);
      chk("wait_addr", imem_addr,     32'h4);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(if_valid), 32'h0);
      chk("arst_pc",    if_pc,         32'h0);
      chk("arst_pc4",   if_pc_plus4,   32'h0);
      chk("arst_instr", if_instr,      32'h0);
      chk("arst_addr",  imem_addr,     32'h0);
      @(negedge clk);
      reset = 1'b0;

      m_pc = 32'h0; m_busy = 1'b0; m_busy_addr = 32'h0; m_doomed = 1'b0;
      m_v = 1'b0; m_spc = 32'h0; m_instr = 32'h0;

      for (int i = 0; i < 3000; i++) begin
         s  = ($urandom_range(0, 99) < 30);
         r  = ($urandom_range(0, 99) < 8);
         rd = ($urandom_range(0, 99) < 60);
         rnd = $urandom;
         rp = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 : (rnd & 32'hFFFF_FFFC);
         stall = s; redirect_valid = r; redirect_pc = rp; imem_ready = rd;
         #1;
         ereq  = m_busy | (~r & (~m_v | ~s));
         eaddr = m_busy ? m_busy_addr : m_pc;
         chk("r_req", 32'(imem_req), 32'(ereq));
         if (ereq) chk("r_addr", imem_addr, eaddr);
         chk("r_valid", 32'(if_valid), 32'(m_v));
         if (m_v) begin
            chk("r_pc",    if_pc,       m_spc);
            chk("r_pc4",   if_pc_plus4, m_spc + 32'd4);
            chk("r_instr", if_instr,    m_instr);
         end
         done = ereq & rd;
         if (r) begin
            m_pc = rp;
            m_v  = 1'b0;
            if (m_busy & ~rd) m_doomed = 1'b1;
         end else if (done & ~m_doomed) begin
            m_v     = 1'b1;
            m_spc   = eaddr;
            m_instr = memf(eaddr);
            m_pc    = eaddr + 32'd4;
         end else if (~s) begin
            m_v = 1'b0;
         end
         if (done) begin
            m_busy   = 1'b0;
            m_doomed = 1'b0;
         end else if (ereq) begin
            m_busy      = 1'b1;
            m_busy_addr = eaddr;
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
